// File: rtl/eq_band_sched_if.sv
// eq_band_sched_if: control bundle between the sample queue / band FIR engines
// and the equalizer band scheduler.
// Optional EQ_BAND_BYPASS_EN adds the per-band enable vector band_en.
interface eq_band_sched_if #(
  parameter int NUM_BANDS = 5
);
  logic                 vld;
  logic                 queue_full;
`ifdef EQ_BAND_BYPASS_EN
  logic [NUM_BANDS-1:0] band_en;
`endif
  logic [NUM_BANDS-1:0] seq;
  logic                 rd_en;
  logic [2:0]           band_idx;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  // Upstream side: codec/queue control drives requests, observes schedule.
  modport master (
`ifdef EQ_BAND_BYPASS_EN
    output band_en,
`endif
    output vld, queue_full,
    input  seq, rd_en, band_idx, busy, done, overrun
  );

  // Scheduler side.
  modport slave (
`ifdef EQ_BAND_BYPASS_EN
    input  band_en,
`endif
    input  vld, queue_full,
    output seq, rd_en, band_idx, busy, done, overrun
  );
endinterface

// File: rtl/eq_band_sched.sv
// eq_band_sched: sequences the per-band FIR engines one at a time for each
// accepted codec sample. Each band gets N_TAPS+1 cycles of seq (clear cycle plus
// accumulate cycles) followed by a single idle gap cycle; done pulses in the
// last band's gap.
// Optional feature macro: EQ_BAND_BYPASS_EN (band_en sampled at accept; disabled
// bands are skipped entirely).
module eq_band_sched #(
  parameter int NUM_BANDS = 5,
  parameter int N_TAPS    = 1021
) (
  input logic           clk,
  input logic           rst_n,
  eq_band_sched_if.slave bus
);
  localparam int CW = $clog2(N_TAPS + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]           state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [2:0]           band_reg, band_next;
  logic [NUM_BANDS-1:0] seq_reg, seq_next, run_onehot;
  logic                 rd_en_reg;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 overrun_reg, overrun_next;

  logic                 accept;
  logic [NUM_BANDS-1:0] en_in;    // enables seen at the accept cycle
  logic [NUM_BANDS-1:0] en_held;  // enables in force for the current run
  logic [2:0]           first_band, later_band;
  logic                 any_first, any_later;

  assign accept = (state_reg == S_IDLE) && bus.vld && bus.queue_full;

`ifdef EQ_BAND_BYPASS_EN
  logic [NUM_BANDS-1:0] band_en_reg;

  assign en_in   = bus.band_en;
  assign en_held = band_en_reg;

  // Capture the band enables once per run so mid-run changes have no effect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      band_en_reg <= '0;
    end else if (accept) begin
      band_en_reg <= bus.band_en;
    end
  end
`else
  assign en_in   = '1;
  assign en_held = '1;
`endif

  // Lowest enabled band at accept, and lowest enabled band above the current one.
  always_comb begin
    first_band = '0;
    any_first  = 1'b0;
    later_band = '0;
    any_later  = 1'b0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (en_in[i]) begin
        first_band = 3'(i);
        any_first  = 1'b1;
      end
      if (en_held[i] && (i > int'(band_reg))) begin
        later_band = 3'(i);
        any_later  = 1'b1;
      end
    end
  end

  // Scheduler FSM: IDLE -> (RUN -> GAP)* -> IDLE; done is decided on GAP entry.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    band_next    = band_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    overrun_next = overrun_reg | (busy_reg & bus.vld);
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          busy_next = 1'b1;
          cnt_next  = '0;
          if (any_first) begin
            state_next = S_RUN;
            band_next  = first_band;
          end else begin
            // Nothing enabled: go straight to a terminal gap carrying done.
            state_next = S_GAP;
            band_next  = '0;
            done_next  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cnt_reg == CW'(N_TAPS)) begin
          state_next = S_GAP;
          done_next  = !any_later;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_GAP: begin
        cnt_next = '0;
        if (done_reg) begin
          state_next = S_IDLE;
          band_next  = '0;
          busy_next  = 1'b0;
        end else begin
          state_next = S_RUN;
          band_next  = later_band;
        end
      end
      default: begin
        state_next = S_IDLE;
        band_next  = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_onehot
      assign run_onehot[gi] = (band_next == 3'(gi));
    end
  endgenerate

  assign seq_next = (state_next == S_RUN) ? run_onehot : '0;

  // State and all outputs registered; seq/rd_en come from the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      band_reg    <= '0;
      seq_reg     <= '0;
      rd_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      band_reg    <= band_next;
      seq_reg     <= seq_next;
      rd_en_reg   <= |seq_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      overrun_reg <= overrun_next;
    end
  end

  assign bus.seq      = seq_reg;
  assign bus.rd_en    = rd_en_reg;
  assign bus.band_idx = band_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_eq_band_sched.sv
// tb_eq_band_sched: randomized and directed bench for eq_band_sched with a
// timeline reference model (offset since accept -> window/position arithmetic).
// Honours EQ_BAND_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_eq_band_sched;
  localparam int NB = 3;
  localparam int NT = 4;
  localparam int W  = NT + 2;   // cycles per band window incl. gap

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_band_sched_if #(.NUM_BANDS(NB)) bus ();
  eq_band_sched #(.NUM_BANDS(NB), .N_TAPS(NT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: busy flag, offset k since accept, list of bands to run.
  bit m_busy;
  int m_k;
  bit m_ovr;
  int m_bands[$];

  function automatic int m_total();
    return (m_bands.size() == 0) ? 1 : m_bands.size() * W;
  endfunction

  task automatic model_edge(input bit v, input bit q, input bit r, input logic [NB-1:0] en);
    logic [NB-1:0] eff;
    eff = en;
`ifndef EQ_BAND_BYPASS_EN
    eff = '1;
`endif
    if (!r) begin
      m_busy = 1'b0;
      m_ovr  = 1'b0;
      m_k    = 0;
    end else if (m_busy) begin
      if (v) m_ovr = 1'b1;
      if (m_k == m_total()) m_busy = 1'b0;
      else m_k++;
    end else if (v && q) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_bands.delete();
      for (int b = 0; b < NB; b++) if (eff[b]) m_bands.push_back(b);
    end
  endtask

  // Expected {seq, rd_en, band_idx, busy, done, overrun} for the current cycle.
  function automatic logic [NB+6:0] m_expect();
    logic [NB-1:0] s;
    logic [2:0]    bi;
    bit            d;
    int            w;
    int            p;
    s  = '0;
    bi = '0;
    d  = 1'b0;
    if (m_busy) begin
      if (m_bands.size() != 0) begin
        w  = (m_k - 1) / W;
        p  = (m_k - 1) % W;
        bi = 3'(m_bands[w]);
        if (p <= NT) s[m_bands[w]] = 1'b1;
      end
      d = (m_k == m_total());
    end
    return {s, |s, bi, m_busy, d, m_ovr};
  endfunction

  function automatic logic [NB+6:0] dut_vec();
    return {bus.seq, bus.rd_en, bus.band_idx, bus.busy, bus.done, bus.overrun};
  endfunction

  // One clock cycle: drive inputs, step the model at the edge, settle to negedge.
  task automatic cyc(input bit v, input bit q, input bit r, input logic [NB-1:0] en);
    bus.vld        = v;
    bus.queue_full = q;
    rst_n          = r;
`ifdef EQ_BAND_BYPASS_EN
    bus.band_en    = en;
`endif
    @(posedge clk);
    model_edge(v, q, r, en);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b0, '1);
    cyc(1'b0, 1'b1, 1'b0, '1);
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", dut_vec(), {(NB+7){1'b0}});
    end
    checks++;
    if (dut_vec() !== m_expect()) begin
      errors++;
      $display("FAIL reset_model got %b want %b", dut_vec(), m_expect());
    end
  endtask

  task automatic test_basic();
    int done_at;
    done_at = -1;
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 22; i++) begin
      cyc(i == 0, 1'b1, 1'b1, '1);   // now in cycle i+1
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL basic cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = i + 1;
      if (i == 0) begin
        checks++;
        if (bus.seq !== 3'b001) begin
          errors++;
          $display("FAIL basic_first_seq got %b want 001", bus.seq);
        end
      end
    end
    checks++;
    if (done_at != NB * W) begin
      errors++;
      $display("FAIL basic_done_cycle got %0d want %0d", done_at, NB * W);
    end
  endtask

  task automatic test_not_full();
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 25; i++) begin
      // vld with queue not full at 0 (ignored), then a real accept at 3
      cyc(i == 0 || i == 3, i >= 3, 1'b1, '1);
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL not_full cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (i == 1) begin
        checks++;
        if ({bus.busy, bus.overrun, bus.seq} !== '0) begin
          errors++;
          $display("FAIL not_full_ignored got %b want 0", {bus.busy, bus.overrun, bus.seq});
        end
      end
    end
  endtask

  task automatic test_overrun();
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 24; i++) begin
      cyc(i == 0 || i == 9 || i == NB * W, 1'b1, 1'b1, '1);
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL overrun cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (i + 1 >= 10 && bus.overrun !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL overrun_sticky cycle %0d got %b want 1", i + 1, bus.overrun);
      end
      if (i + 1 == NB * W + 1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL overrun_done_vld_accepted got busy %b want 0", bus.busy);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen_done;
    seen_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 16; i++) begin
      cyc(i == 0 || i == 12, 1'b1, i != 10, '1);
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL mid_reset cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (i < 12 && bus.done === 1'b1) seen_done = 1'b1;
      if (i == 10) begin
        checks++;
        if (dut_vec() !== '0) begin
          errors++;
          $display("FAIL mid_reset_clear got %b want 0", dut_vec());
        end
      end
      if (i == 12) begin
        checks++;
        if (bus.seq !== 3'b001) begin
          errors++;
          $display("FAIL mid_reset_restart got %b want 001", bus.seq);
        end
      end
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL mid_reset_done got 1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 40; i++) begin
      cyc(i == 0 || i == NB * W + 1, 1'b1, 1'b1, '1);
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL b2b cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (bus.done === 1'b1) dones.push_back(i + 1);
    end
    checks++;
    if (dones.size() != 2 || dones[dones.size()-1] != 2 * NB * W + 1) begin
      errors++;
      $display("FAIL b2b_done count %0d last %0d want 2 at %0d", dones.size(),
               (dones.size() > 0) ? dones[dones.size()-1] : -1, 2 * NB * W + 1);
    end
  endtask

`ifdef EQ_BAND_BYPASS_EN
  task automatic test_bypass();
    int done_at;
    done_at = -1;
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 14; i++) begin
      cyc(i == 0, 1'b1, 1'b1, (i == 0) ? 3'b101 : 3'b010);
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL bypass cycle %0d got %b want %b", i + 1, dut_vec(), m_expect());
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = i + 1;
    end
    checks++;
    if (done_at != 2 * W) begin
      errors++;
      $display("FAIL bypass_done got %0d want %0d", done_at, 2 * W);
    end
    cyc(1'b1, 1'b1, 1'b1, 3'b000);
    checks++;
    if ({bus.done, bus.busy, bus.seq} !== {1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL bypass_none got %b want 11000", {bus.done, bus.busy, bus.seq});
    end
  endtask
`endif

  task automatic test_random();
    cyc(1'b0, 1'b0, 1'b0, '1);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 199) != 0, NB'($urandom));
      checks++;
      if (dut_vec() !== m_expect()) begin
        errors++;
        $display("FAIL random cycle %0d got %b want %b", i, dut_vec(), m_expect());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_not_full();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
`ifdef EQ_BAND_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
